// File: rtl/polar_seq_ctrl.sv
// Cartesian-to-polar sequencer: one shared iterative datapath computes the exact
// floor(sqrt(x^2 + y^2)), saturated to 8 bits, and then floor(x/y) for one operand pair.
module polar_seq_ctrl #(
    parameter logic [7:0] DIV_ZERO_VAL = 8'd90,
    parameter logic [8:0] R_SAT        = 9'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r,
    output logic [7:0] q,
    output logic       busy,
    output logic [7:0] ops
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SQ   = 3'd1;
    localparam logic [2:0] SQRT = 3'd2;
    localparam logic [2:0] DIV  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state;
    logic [7:0]  xa, ya;
    logic [17:0] sum_sh;   // radicand, consumed two bits per iteration from the top
    logic [9:0]  srem;
    logic [8:0]  root;
    logic [3:0]  iter;
    logic [7:0]  drem;
    logic [7:0]  dvd;      // dividend shifts out at the top while quotient bits shift in

    logic [16:0] sum_c;
    logic [11:0] s_rem_sh, s_trial;
    logic        s_ge;
    logic [8:0]  d_rem_sh;
    logic        d_ge;
    logic [7:0]  r_sat;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sum_c    = 17'd0;
        s_rem_sh = 12'd0;
        s_trial  = 12'd0;
        s_ge     = 1'b0;
        d_rem_sh = 9'd0;
        d_ge     = 1'b0;
        r_sat    = 8'd0;

        sum_c    = {9'd0, xa} * {9'd0, xa} + {9'd0, ya} * {9'd0, ya};
        s_rem_sh = {srem, sum_sh[17:16]};
        s_trial  = {1'b0, root, 2'b01};
        s_ge     = (s_rem_sh >= s_trial);
        d_rem_sh = {drem, dvd[7]};
        d_ge     = (d_rem_sh >= {1'b0, ya});
        r_sat    = (root > R_SAT) ? R_SAT[7:0] : root[7:0];
    end

    assign in_ready  = ena && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            xa     <= '0;
            ya     <= '0;
            sum_sh <= '0;
            srem   <= '0;
            root   <= '0;
            iter   <= '0;
            drem   <= '0;
            dvd    <= '0;
            r      <= '0;
            q      <= '0;
            ops    <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xa    <= x;
                        ya    <= y;
                        state <= SQ;
                    end
                end
                SQ: begin
                    sum_sh <= {1'b0, sum_c};
                    srem   <= '0;
                    root   <= '0;
                    iter   <= '0;
                    state  <= SQRT;
                end
                SQRT: begin
                    // A failed trial leaves the shifted remainder below the trial, so it fits in 10 bits.
                    if (s_ge) begin
                        srem <= 10'(s_rem_sh - s_trial);
                        root <= {root[7:0], 1'b1};
                    end else begin
                        srem <= s_rem_sh[9:0];
                        root <= {root[7:0], 1'b0};
                    end
                    sum_sh <= {sum_sh[15:0], 2'b00};
                    if (iter == 4'd8) begin
                        iter  <= '0;
                        drem  <= '0;
                        dvd   <= xa;
                        state <= DIV;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                DIV: begin
                    if (ya == 8'd0) begin
                        r     <= r_sat;
                        q     <= DIV_ZERO_VAL;
                        state <= DONE;
                    end else begin
                        drem <= d_ge ? 8'(d_rem_sh - {1'b0, ya}) : d_rem_sh[7:0];
                        dvd  <= {dvd[6:0], d_ge};
                        if (iter == 4'd7) begin
                            r     <= r_sat;
                            q     <= {dvd[6:0], d_ge};
                            iter  <= '0;
                            state <= DONE;
                        end else begin
                            iter <= iter + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ops   <= ops + 8'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_seq_ctrl.sv
// Scoreboard bench for polar_seq_ctrl: expected results are queued at accept and compared
// on each output transfer, alongside latency, backpressure, enable, reset and wrap checks.
module tb_polar_seq_ctrl;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] q;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] r, q;
    logic       busy;
    logic [7:0] ops;

    result_t    sb[$];
    logic [7:0] exp_ops = '0;
    int         n_checks = 0;
    int         n_fails = 0;

    polar_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .r(r), .q(q),
        .busy(busy), .ops(ops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic result_t model(input logic [7:0] xa, input logic [7:0] ya);
        result_t res;
        int s, k;
        s = int'(xa) * int'(xa) + int'(ya) * int'(ya);
        k = 0;
        while ((k + 1) * (k + 1) <= s) k++;
        res.r = (k > 255) ? 8'd255 : 8'(k);
        res.q = (ya == 8'd0) ? 8'd90 : 8'(int'(xa) / int'(ya));
        return res;
    endfunction

    // Output side of the scoreboard: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && ena && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = sb.pop_front();
                check("r", {24'd0, r}, {24'd0, e.r});
                check("q", {24'd0, q}, {24'd0, e.q});
            end
            exp_ops = exp_ops + 8'd1;
        end
    end

    // mode 0: out_ready high; mode 1: 5 cycles of backpressure; mode 2: ena low in DONE
    task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input int exp_lat,
                          input int drop_at, input int mode);
        int n;
        result_t e;
        out_ready = (mode == 0);
        for (int i = 0; i < 50 && !in_ready; i++) step();
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x = xa;
        y = ya;
        sb.push_back(model(xa, ya));
        e = model(xa, ya);
        step();
        in_valid = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            ena = !(drop_at > 0 && i > drop_at && i <= drop_at + 3);
            step();
            n = i;
            if (!ena) check("in_ready_ena_low", {31'd0, in_ready}, 32'd0);
            if (out_valid) break;
        end
        ena = 1'b1;
        check("latency", n, exp_lat);
        if (mode == 1) begin
            for (int i = 0; i < 5; i++) begin
                check("bp_r", {24'd0, r}, {24'd0, e.r});
                check("bp_q", {24'd0, q}, {24'd0, e.q});
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_ops", {24'd0, ops}, {24'd0, exp_ops});
                step();
            end
            out_ready = 1'b1;
        end
        if (mode == 2) begin
            ena = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                check("ena_low_out_valid", {31'd0, out_valid}, 32'd1);
                check("ena_low_ops", {24'd0, ops}, {24'd0, exp_ops});
            end
            ena = 1'b1;
        end
        step();
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_ops", {24'd0, ops}, {24'd0, exp_ops});
        check("post_r_hold", {24'd0, r}, {24'd0, e.r});
    endtask

    initial begin
        #2;
        check("rst_r", {24'd0, r}, 32'd0);
        check("rst_q", {24'd0, q}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ops", {24'd0, ops}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        step();

        run_op(8'd3,   8'd4,   18, 0, 0);
        run_op(8'd255, 8'd255, 18, 0, 0);
        run_op(8'd200, 8'd0,   11, 0, 0);
        run_op(8'd0,   8'd0,   11, 0, 0);
        run_op(8'd100, 8'd7,   18, 0, 0);
        run_op(8'd50,  8'd9,   18, 0, 1);
        run_op(8'd6,   8'd8,   21, 4, 0);
        run_op(8'd17,  8'd3,   18, 0, 2);

        // Abort an operation while it is dividing.
        out_ready = 1'b1;
        in_valid = 1'b1;
        x = 8'd100;
        y = 8'd7;
        step();
        in_valid = 1'b0;
        repeat (13) step();
        check("mid_div_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_r", {24'd0, r}, 32'd0);
        check("arst_q", {24'd0, q}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ops", {24'd0, ops}, 32'd0);
        sb.delete();
        exp_ops = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] xv, yv;
            xv = 8'($urandom);
            yv = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            run_op(xv, yv, (yv == 8'd0) ? 11 : 18, 0, 0);
        end
        check("ops_wrap", {24'd0, ops}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/polar_seq_ctrl.md
Name: polar_seq_ctrl

Overview:
Multi-cycle sequencer for the cartesian-to-polar path. It accepts one (x, y) pair through a valid/ready handshake and schedules a single shared iterative unit. That unit first computes the exact floor(sqrt(x²+y²)) and then the integer ratio floor(x/y). Results are returned through a valid/ready output handshake. This replaces the single-cycle top-byte approximation: r becomes the exact floor root, saturated to 8 bits.

Parameters:
DIV_ZERO_VAL, 90, q value returned when y == 0 (8-bit).
R_SAT, 255, saturation ceiling applied to the 9-bit root before output.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when low, all state is frozen
in_valid  input  1  x/y valid
in_ready  output  1  block can accept an operand pair
x  input  8  unsigned x operand
y  input  8  unsigned y operand
out_valid  output  1  r/q valid
out_ready  input  1  consumer accepts the result
r  output  8  min(floor(sqrt(x²+y²)), R_SAT)
q  output  8  floor(x/y), or DIV_ZERO_VAL when y == 0
busy  output  1  high in any state other than IDLE
ops  output  8  count of completed output transfers, wraps 255->0

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: FSM = IDLE; r, q, ops, out_valid, busy = 0; in_ready = 1 (gated by ena). All internal registers are cleared.
- Reset mid-operation: the operation is aborted, nothing is output, and the block returns to IDLE.
- ena low:
  - State, counters and registers are held.
  - in_ready is forced low.
  - out_valid holds its value, but no transfer completes while ena = 0, even if out_ready = 1.
- FSM states: IDLE, SQ, SQRT, DIV, DONE.
- IDLE:
  - in_ready = ena.
  - Accept occurs when in_valid && in_ready at a rising edge: capture x and y, go to SQ.
- SQ (1 cycle): sum = x*x + y*y as a 17-bit unsigned value (maximum 130050, no truncation). Go to SQRT.
- SQRT (9 cycles):
  - Restoring bit-serial square root, one result bit per cycle, MSB first, with a 4-bit iteration counter.
  - At the end, root is 9 bits (maximum 360).
  - r_next = (root > R_SAT) ? R_SAT : root[7:0].
  - Go to DIV.
- DIV:
  - If y == 0: one cycle, q_next = DIV_ZERO_VAL.
  - Otherwise: 8 cycles of restoring division, one quotient bit per cycle, MSB first. Remainder is 9 bits. Quotient is exact, range 0..255.
  - Then load the r and q output registers and go to DONE.
- DONE:
  - out_valid = 1; r and q are stable.
  - On out_valid && out_ready && ena: out_valid falls, ops increments, go to IDLE.
  - No bypass: a new accept is possible no earlier than the cycle after the transfer.
- Latency, counting rising edges after the accept edge (ena held high):
  - y != 0: out_valid is high after edge 18.
  - y == 0: out_valid is high after edge 11.
  - Each ena-low cycle adds exactly one cycle of latency.
- Output stability: r and q change only when entering DONE. They hold their last values otherwise, including in IDLE after a transfer.
- Simultaneous events: in_valid during non-IDLE states is ignored (in_ready = 0). The inputs x and y may change freely after the accept edge.
- Wrap-around: the ops counter wraps 255 -> 0 with no flag.
- Arithmetic: all values are unsigned. No intermediate result may be truncated below its stated width.

Test Plan:
- x=3, y=4, out_ready=1 -> r=5, q=0; out_valid high after edge 18; ops=1; busy low the next cycle.
- x=255, y=255 -> sum=130050, root=360 -> r=255 (saturated), q=1. Then x=200, y=0 -> r=200, q=90, latency 11 edges.
- x=0, y=0 -> r=0, q=90. Then x=100, y=7 -> r=100, q=14.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> r, q and out_valid stable; in_ready=0; ops unchanged; transfer occurs on the first out_ready=1 edge.
- ena dropped for 3 cycles mid-SQRT, with x=6, y=8 -> r=10, q=0, latency 21 edges. ena=0 while in DONE with out_ready=1 -> no transfer.
- Reset pulse mid-DIV -> r=q=out_valid=ops=0 immediately (asynchronous); in_ready=1 after release. Then 256 back-to-back transfers -> ops wraps to 0.
